pool_2x2_feeder: RTL and testbench

//  Streaming front end that drives the 2x2 max-pooling comparator stage.

---
 rtl/pool_2x2_feeder.sv | 108 ++++++++++
 tb/tb_pool_2x2_feeder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pool_2x2_feeder.sv
// pool_2x2_feeder: raster-order front end for a 2x2 max-pooling stage.
// Even rows are captured into a one-row line buffer. During each odd row, the
// buffered upper pixel and the incoming lower pixel are presented to the
// pooler as a vertical pair. The pooler's registered result is returned one
// cycle after each odd-column pair, together with frame markers.
module pool_2x2_feeder #(
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] pool_a,
    output logic [DATA_W-1:0] pool_b,
    output logic              pool_store,
    input  logic [DATA_W-1:0] pool_result,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] linebuf [IMG_W];

    logic accept;
    logic col_end;
    logic row_end;
    logic odd_beat;

    // A beat is refused only in a cycle where reset or flush is asserted.
    // Because flush blocks acceptance, a pixel presented with flush is dropped.
    assign in_ready = ~(rst | flush);
    assign accept   = in_valid & in_ready;
    assign col_end  = (col == COL_W'(IMG_W - 1));
    assign row_end  = (row == ROW_W'(IMG_H - 1));
    assign odd_beat = accept & (state == ROW_ODD);

    // The pooler registers its own result, so the pooled pixel goes straight out.
    assign out_data = pool_result;

    // Present the (upper, lower) pair in the same cycle as the lower-row beat.
    always_comb begin
        // NOTE: every output receives a default first, so no path can leave one
        // unassigned and infer a latch.
        pool_a     = '0;
        pool_b     = '0;
        pool_store = 1'b0;
        if (odd_beat) begin
            pool_a     = linebuf[col];
            pool_b     = in_data;
            pool_store = ~col[0];
        end
    end

    // Capture the upper row of each row pair.
    // NOTE: the line buffer is deliberately left out of reset. Each even row
    // is fully rewritten before it is read, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (accept && state == ROW_EVEN) begin
            linebuf[col] <= in_data;
        end
    end

    // Raster counters, row-pair FSM and registered output strobes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so each
        // register sees the values from before this edge, regardless of
        // statement order.
        if (rst || flush) begin
            state      <= ROW_EVEN;
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // The pooler result for an odd-column pair is ready one cycle later.
            out_valid  <= odd_beat & col[0];
            out_last   <= odd_beat & col_end & row_end;
            frame_done <= odd_beat & col_end & row_end;
            if (accept) begin
                if (col_end) begin
                    col   <= '0;
                    row   <= row_end ? '0 : row + 1'b1;
                    state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_2x2_feeder.sv
// Directed bench for pool_2x2_feeder on a 4x4 map, with a behavioural FP16 max
// pooler attached. Each cycle runs through one task: it checks the outputs
// owed from the previous cycle, drives new inputs, then checks the pooler
// interface for the beat it just drove.
module tb_pool_2x2_feeder;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 16;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          flush    = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic [DW-1:0] pool_a;
    logic [DW-1:0] pool_b;
    logic          pool_store;
    logic [DW-1:0] pool_result = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Output that the next cycle must show, as implied by the beat just driven.
    logic          pend_v    = 1'b0;
    logic          pend_last = 1'b0;
    logic [DW-1:0] pend_d    = '0;

    logic [DW-1:0] pix  [2][H][W];
    logic [DW-1:0] expw [2][H/2][W/2];
    logic [DW-1:0] left = '0;

    pool_2x2_feeder #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .pool_a     (pool_a),
        .pool_b     (pool_b),
        .pool_store (pool_store),
        .pool_result(pool_result),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Map an FP16 pattern to an unsigned key that orders the same as the value.
    function automatic logic [15:0] fkey(input logic [15:0] x);
        return x[15] ? ~x : (x | 16'h8000);
    endfunction

    function automatic logic [15:0] fmax(input logic [15:0] a, input logic [15:0] b);
        return (fkey(a) >= fkey(b)) ? a : b;
    endfunction

    // Behavioural pooler. On a store strobe it latches the left half. Its
    // result register always holds max(left, a, b) from the previous cycle.
    always @(posedge clk) begin
        if (pool_store) left <= fmax(pool_a, pool_b);
        pool_result <= fmax(left, fmax(pool_a, pool_b));
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input logic [15:0] d, input bit fl, input bit rs,
                         input bit odd_beat, input bit odd_col, input logic [15:0] upper,
                         input logic [15:0] exp_win, input bit last_win);
        @(negedge clk);
        check("out_valid", 16'(out_valid), 16'(pend_v));
        check("out_last", 16'(out_last), 16'(pend_v & pend_last));
        check("frame_done", 16'(frame_done), 16'(pend_v & pend_last));
        if (pend_v) check("out_data", out_data, pend_d);
        in_valid = v;
        in_data  = d;
        flush    = fl;
        rst      = rs;
        #1;
        check("in_ready", 16'(in_ready), 16'(!(fl || rs)));
        check("pool_store", 16'(pool_store), 16'(odd_beat && !odd_col));
        if (odd_beat) begin
            check("pool_a", pool_a, upper);
            check("pool_b", pool_b, d);
        end
        pend_v    = odd_beat && odd_col;
        pend_d    = exp_win;
        pend_last = last_win;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Send the first n beats of frame f, with 'gap' idle cycles before each odd-row odd-column beat.
    task automatic send_beats(input int f, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            int r;
            int c;
            r = k / W;
            c = k % W;
            if ((r % 2 == 1) && (c % 2 == 1)) repeat (gap) idle();
            cycle(1'b1, pix[f][r][c], 1'b0, 1'b0, r % 2 == 1, c % 2 == 1,
                  pix[f][r & ~1][c], expw[f][r/2][c/2], (r == H-1) && (c == W-1));
        end
    endtask

    initial begin
        // Frame 0: 1,2,3,4 / -1,4,1,1 / 3,3,3,3 / 0,2,-1,4
        pix[0] = '{'{16'h3C00, 16'h4000, 16'h4200, 16'h4400},
                   '{16'hBC00, 16'h4400, 16'h3C00, 16'h3C00},
                   '{16'h4200, 16'h4200, 16'h4200, 16'h4200},
                   '{16'h0000, 16'h4000, 16'hBC00, 16'h4400}};
        expw[0] = '{'{16'h4400, 16'h4400}, '{16'h4200, 16'h4400}};
        // Frame 1: 4,1,0,-1 / 2,3,-2,-4 / 1,1,1,1 / 6,0,0.5,-1
        pix[1] = '{'{16'h4400, 16'h3C00, 16'h0000, 16'hBC00},
                   '{16'h4000, 16'h4200, 16'hC000, 16'hC400},
                   '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00},
                   '{16'h4600, 16'h0000, 16'h3800, 16'hBC00}};
        expw[1] = '{'{16'h4400, 16'h0000}, '{16'h4600, 16'h3C00}};

        // Reset state
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        check("reset pool_a", pool_a, 16'h0000);
        check("reset pool_b", pool_b, 16'h0000);

        // T1 and T6: a single frame, with the pooler interface checked on every beat
        send_beats(0, W*H, 0);
        idle();

        // T2: three stall cycles inside each odd-row window pair
        send_beats(0, W*H, 3);
        idle();

        // T3: two frames back to back with no gap cycle
        send_beats(0, W*H, 0);
        send_beats(1, W*H, 0);
        idle();

        // T4: flush together with the pixel at row 1, col 1; the pixel is dropped
        send_beats(1, W + 1, 0);
        cycle(1'b1, pix[1][1][1], 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        send_beats(1, W*H, 0);
        idle();
        // A flush right after a window issues still lets that output fire
        send_beats(0, W + 2, 0);
        cycle(1'b1, pix[0][1][2], 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        send_beats(0, W*H, 0);
        idle();

        // T5: reset in the middle of an odd row, then a fresh frame
        send_beats(1, W + 2, 0);
        cycle(1'b1, pix[1][1][2], 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        idle();
        check("post-rst pool_a", pool_a, 16'h0000);
        check("post-rst pool_b", pool_b, 16'h0000);
        send_beats(0, W*H, 0);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
